// File: rtl/traffic_pkg.sv
// Shared lamp and phase encodings for the traffic phase sequencer.
// Pure declarations: no logic, no latency, no flow control.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2
    } phase_t;

endpackage

// File: rtl/traffic_phase_sequencer_phase_timer.sv
// phase_timer: loadable tick-enabled down-counter; expired flags the tick that ends a dwell.
// Latency: load takes effect next clk; expired is combinational from the count and tick.
// No backpressure; freeze holds the count and masks expiry.
module phase_timer #(
    parameter int               CNT_W   = 4,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             freeze,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && !freeze && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = tick && !freeze && (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: N-road GREEN/YELLOW/ALL_RED controller timed on an external tick strobe.
// Latency: phase/lights change the clk after a qualifying tick; phase_done is a registered pulse.
// No backpressure; tick=0 freezes all state. Optional preemption under TRAFFIC_PREEMPT_EN.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int NUM_ROADS     = 4,
    parameter int CNT_W         = 4,
    parameter int YELLOW_TICKS  = 2,
    parameter int ALL_RED_TICKS = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic                         actuated_mode,
    input  logic [NUM_ROADS-1:0]         req,
    input  logic [NUM_ROADS*CNT_W-1:0]   green_time,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic                         preempt_valid,
    input  logic [$clog2(NUM_ROADS)-1:0] preempt_road,
    output logic                         preempt_active,
`endif
    output logic [NUM_ROADS*3-1:0]       lights,
    output logic [$clog2(NUM_ROADS)-1:0] cur_road,
    output logic [1:0]                   phase,
    output logic                         phase_done
);

    localparam int RW = $clog2(NUM_ROADS);

    phase_t           phase_q, phase_d;
    logic [RW-1:0]    cur_road_q, cur_road_d;
    logic             phase_done_q;
    logic             ld;
    logic [CNT_W-1:0] ld_val;
    logic             freeze;
    logic             expired;
    logic             sel_vld;
    logic [RW-1:0]    sel_road;
    logic [CNT_W-1:0] sel_gt;
    logic             pre_vld;
    logic [RW-1:0]    pre_road;

`ifdef TRAFFIC_PREEMPT_EN
    logic preempt_active_q;

    assign pre_vld  = preempt_valid;
    assign pre_road = preempt_road;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            preempt_active_q <= 1'b0;
        end else begin
            preempt_active_q <= preempt_valid;
        end
    end

    assign preempt_active = preempt_active_q;
`else
    assign pre_vld  = 1'b0;
    assign pre_road = '0;
`endif

    function automatic logic [RW-1:0] wrap_add(input logic [RW-1:0] r, input int k);
        int s;
        s = int'(r) + k;
        if (s >= NUM_ROADS) s = s - NUM_ROADS;
        return RW'(s);
    endfunction

    // Actuated scan starts after cur_road and visits cur_road last.
    always_comb begin
        sel_vld  = 1'b0;
        sel_road = cur_road_q;
        if (pre_vld) begin
            sel_vld  = 1'b1;
            sel_road = pre_road;
        end else if (!actuated_mode) begin
            sel_vld  = 1'b1;
            sel_road = wrap_add(cur_road_q, 1);
        end else begin
            for (int k = 1; k <= NUM_ROADS; k++) begin
                if (!sel_vld && req[wrap_add(cur_road_q, k)]) begin
                    sel_vld  = 1'b1;
                    sel_road = wrap_add(cur_road_q, k);
                end
            end
        end
    end

    assign sel_gt = green_time[int'(sel_road)*CNT_W +: CNT_W];

    always_comb begin
        phase_d    = phase_q;
        cur_road_d = cur_road_q;
        ld         = 1'b0;
        ld_val     = '0;
        freeze     = pre_vld && (phase_q == PH_GREEN) && (cur_road_q == pre_road);
        case (phase_q)
            PH_GREEN: begin
                if ((pre_vld && (cur_road_q != pre_road)) || expired) begin
                    phase_d = PH_YELLOW;
                    ld      = 1'b1;
                    ld_val  = CNT_W'(YELLOW_TICKS - 1);
                end
            end
            PH_YELLOW: begin
                if (expired) begin
                    phase_d = PH_ALL_RED;
                    ld      = 1'b1;
                    ld_val  = CNT_W'(ALL_RED_TICKS - 1);
                end
            end
            default: begin
                // With no selectable road the counter rests at zero, so every tick re-evaluates.
                if (expired && sel_vld) begin
                    phase_d    = PH_GREEN;
                    cur_road_d = sel_road;
                    ld         = 1'b1;
                    ld_val     = (sel_gt == '0) ? '0 : sel_gt - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= PH_ALL_RED;
            cur_road_q   <= RW'(NUM_ROADS - 1);
            phase_done_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            cur_road_q   <= cur_road_d;
            phase_done_q <= (phase_d != phase_q);
        end
    end

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(ALL_RED_TICKS - 1))
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (ld),
        .load_val (ld_val),
        .freeze   (freeze),
        .expired  (expired)
    );

    always_comb begin
        lights = '0;
        for (int i = 0; i < NUM_ROADS; i++) begin
            lights[i*3 +: 3] = LIGHT_RED;
            if (cur_road_q == RW'(i)) begin
                if (phase_q == PH_GREEN)       lights[i*3 +: 3] = LIGHT_GREEN;
                else if (phase_q == PH_YELLOW) lights[i*3 +: 3] = LIGHT_YELLOW;
            end
        end
    end

    assign cur_road   = cur_road_q;
    assign phase      = phase_q;
    assign phase_done = phase_done_q;

endmodule
